led_mode_ctrl: RTL and testbench

Sequencer for the 4-LED display that turns debounced key events into LED pattern and speed changes. It sits downstream of the key debouncers and consumes their `flag`/`key_value` pairs. It owns the tick divider and the pattern register that drive `led[3:0]`, so the free-running fixed-period LED shifter is no longer needed.

---
 rtl/led_pkg.sv | 75 +++++++
 rtl/key_press_detect.sv | 29 ++
 rtl/led_mode_ctrl.sv | 149 ++++++++++++++
 tb/tb_led_mode_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the LED mode/speed sequencer.
// Holds the display mode enum, the pattern constants loaded on mode entry,
// the speed encoding, and small pure helpers for mode/speed/pattern stepping.
package led_pkg;

    // Display modes, in key-press cycling order.
    typedef enum logic [1:0] {
        RUN_R = 2'd0,
        RUN_L = 2'd1,
        BLINK = 2'd2,
        OFF   = 2'd3
    } mode_e;

    // Patterns loaded when a mode is entered.
    localparam logic [3:0] PAT_RUN = 4'b0001;
    localparam logic [3:0] PAT_ALL = 4'b1111;
    localparam logic [3:0] PAT_OFF = 4'b0000;

    // Speed encoding: 0 slow, 1 mid, 2 fast.
    typedef logic [1:0] speed_t;
    localparam speed_t SPEED_0   = 2'd0;
    localparam speed_t SPEED_1   = 2'd1;
    localparam speed_t SPEED_MAX = 2'd2;

    // Next mode in the RUN_R -> RUN_L -> BLINK -> OFF -> RUN_R ring.
    function automatic mode_e next_mode(input mode_e m);
        mode_e r;
        case (m)
            RUN_R:   r = RUN_L;
            RUN_L:   r = BLINK;
            BLINK:   r = OFF;
            OFF:     r = RUN_R;
            default: r = RUN_R;
        endcase
        return r;
    endfunction

    // Pattern shown immediately on entering a mode.
    function automatic logic [3:0] entry_pattern(input mode_e m);
        logic [3:0] r;
        case (m)
            RUN_R:   r = PAT_RUN;
            RUN_L:   r = PAT_RUN;
            BLINK:   r = PAT_ALL;
            OFF:     r = PAT_OFF;
            default: r = PAT_OFF;
        endcase
        return r;
    endfunction

    // One divider step of the pattern for the given mode.
    function automatic logic [3:0] step_pattern(input mode_e m, input logic [3:0] p);
        logic [3:0] r;
        case (m)
            RUN_R:   r = {p[0], p[3:1]};
            RUN_L:   r = {p[2:0], p[3]};
            BLINK:   r = ~p;
            OFF:     r = PAT_OFF;
            default: r = PAT_OFF;
        endcase
        return r;
    endfunction

    // Next speed in the 0 -> 1 -> 2 -> 0 ring.
    function automatic speed_t next_speed(input speed_t s);
        speed_t r;
        if (s >= SPEED_MAX) begin
            r = SPEED_0;
        end else begin
            r = s + 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// key_press_detect: turns a debouncer's flag/value stream into a single
// press pulse per physical press. The last accepted stable level is kept;
// a press is a flag carrying level 0 while the stored level is still 1.
// The pulse is combinational so the consumer can act on the same edge the
// flag is sampled, giving a one-cycle flag-to-output latency.
module key_press_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic flag,
    input  logic value,
    output logic press
);

    logic level_r;

    // Remember the last stable level reported by the debouncer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b1;
        end else if (flag) begin
            level_r <= value;
        end else begin
            level_r <= level_r;
        end
    end

    assign press = flag & ~value & level_r;

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: key-driven sequencer for the 4-LED display.
// A mode key cycles RUN_R/RUN_L/BLINK/OFF and reloads the pattern; a speed
// key cycles among three step periods. A divider counts 0..N-1 and steps the
// pattern on wrap, pulsing tick with the new pattern. Any press restarts the
// divider and suppresses the step of that cycle.
// Build option: define LED_SPEED_EN to enable the speed key and the
// three-period select; otherwise speed is fixed at 0 and N = TICK_SLOW.
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int TICK_SLOW = 25_000_000,
    parameter int TICK_MID  = 12_500_000,
    parameter int TICK_FAST = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_flag,
    input  logic       mode_value,
    input  logic       spd_flag,
    input  logic       spd_value,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       tick
);

    localparam int CNT_W = (TICK_SLOW > 2) ? $clog2(TICK_SLOW) : 1;

    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(TICK_SLOW - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] cnt_last_s;
    logic [3:0]       led_r;
    logic [3:0]       led_s;
    mode_e            mode_r;
    mode_e            mode_s;
    speed_t           speed_r;
    speed_t           speed_s;
    logic             tick_r;
    logic             tick_s;
    logic             mode_press_s;
    logic             spd_press_s;

    key_press_detect u_mode_key (
        .clk   (clk),
        .rst_n (rst_n),
        .flag  (mode_flag),
        .value (mode_value),
        .press (mode_press_s)
    );

`ifdef LED_SPEED_EN
    localparam logic [CNT_W-1:0] LAST_MID  = CNT_W'(TICK_MID - 1);
    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(TICK_FAST - 1);

    key_press_detect u_spd_key (
        .clk   (clk),
        .rst_n (rst_n),
        .flag  (spd_flag),
        .value (spd_value),
        .press (spd_press_s)
    );

    // Select the terminal count for the current speed.
    always_comb begin
        cnt_last_s = LAST_SLOW;
        case (speed_r)
            SPEED_0: cnt_last_s = LAST_SLOW;
            SPEED_1: cnt_last_s = LAST_MID;
            default: cnt_last_s = LAST_FAST;
        endcase
    end
`else
    // Speed key is not decoded in this build; its pins only feed this sink.
    logic unused_spd_s;
    localparam int unused_tick_cfg = TICK_MID + TICK_FAST;

    assign unused_spd_s = spd_flag ^ spd_value;
    assign spd_press_s  = 1'b0;
    assign cnt_last_s   = LAST_SLOW;
`endif

    // Next-state for mode, speed, pattern, divider and tick; presses win over steps.
    always_comb begin
        mode_s  = mode_r;
        speed_s = speed_r;
        led_s   = led_r;
        cnt_s   = cnt_r;
        tick_s  = 1'b0;
        if (mode_press_s || spd_press_s) begin
            cnt_s = CNT_ZERO;
            if (mode_press_s) begin
                mode_s = next_mode(mode_r);
                led_s  = entry_pattern(next_mode(mode_r));
            end else begin
                mode_s = mode_r;
                led_s  = led_r;
            end
            if (spd_press_s) begin
                speed_s = next_speed(speed_r);
            end else begin
                speed_s = speed_r;
            end
        end else if (cnt_r == cnt_last_s) begin
            cnt_s  = CNT_ZERO;
            led_s  = step_pattern(mode_r, led_r);
            tick_s = 1'b1;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= RUN_R;
            led_r   <= PAT_RUN;
            cnt_r   <= CNT_ZERO;
            tick_r  <= 1'b0;
        end else begin
            mode_r  <= mode_s;
            led_r   <= led_s;
            cnt_r   <= cnt_s;
            tick_r  <= tick_s;
        end
    end

`ifdef LED_SPEED_EN
    // Speed register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_r <= SPEED_0;
        end else begin
            speed_r <= speed_s;
        end
    end
`else
    assign speed_r = SPEED_0;
`endif

    assign led   = led_r;
    assign mode  = mode_r;
    assign speed = speed_r;
    assign tick  = tick_r;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed bench for led_mode_ctrl with TICK 8/4/2.
// A behavioural model derives the display from mode, number of steps since
// the last mode entry and cycles since the last restart; it is compared to
// the DUT every falling clock edge. Literal checks pin key moments.
`timescale 1ns/1ps
module tb_led_mode_ctrl;

    localparam int TS = 8;
    localparam int TM = 4;
    localparam int TF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_flag = 1'b0;
    logic       mode_value = 1'b1;
    logic       spd_flag = 1'b0;
    logic       spd_value = 1'b1;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       tick;

    int n_checks = 0;
    int n_pass = 0;

    // model state
    int m_mode = 0;
    int m_speed = 0;
    int m_steps = 0;
    int m_since = 0;
    bit m_tick = 1'b0;
    bit m_lvl_mode = 1'b1;
    bit m_lvl_spd = 1'b1;

    led_mode_ctrl #(.TICK_SLOW(TS), .TICK_MID(TM), .TICK_FAST(TF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_flag  (mode_flag),
        .mode_value (mode_value),
        .spd_flag   (spd_flag),
        .spd_value  (spd_value),
        .led        (led),
        .mode       (mode),
        .speed      (speed),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    function automatic int period(input int s);
`ifdef LED_SPEED_EN
        if (s == 0) return TS;
        else if (s == 1) return TM;
        else return TF;
`else
        return TS;
`endif
    endfunction

    // Display after st steps from entry of mode md.
    function automatic int exp_led(input int md, input int st);
        int k;
        case (md)
            0: begin k = (4 - (st % 4)) % 4; return 1 << k; end
            1: begin k = st % 4; return 1 << k; end
            2: return ((st % 2) == 0) ? 15 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model advancing on each clock edge.
    always @(posedge clk or negedge rst_n) begin : mdl
        bit mp;
        bit sp;
        if (!rst_n) begin
            m_mode <= 0; m_speed <= 0; m_steps <= 0; m_since <= 0;
            m_tick <= 1'b0; m_lvl_mode <= 1'b1; m_lvl_spd <= 1'b1;
        end else begin
            mp = mode_flag && !mode_value && m_lvl_mode;
            if (mode_flag) m_lvl_mode <= mode_value;
`ifdef LED_SPEED_EN
            sp = spd_flag && !spd_value && m_lvl_spd;
            if (spd_flag) m_lvl_spd <= spd_value;
`else
            sp = 1'b0;
`endif
            if (mp || sp) begin
                if (mp) begin
                    m_mode <= (m_mode + 1) % 4;
                    m_steps <= 0;
                end
                if (sp) m_speed <= (m_speed + 1) % 3;
                m_since <= 0;
                m_tick <= 1'b0;
            end else if (m_since + 1 == period(m_speed)) begin
                m_since <= 0;
                m_steps <= m_steps + 1;
                m_tick <= 1'b1;
            end else begin
                m_since <= m_since + 1;
                m_tick <= 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        check("led", int'(led), exp_led(m_mode, m_steps));
        check("mode", int'(mode), m_mode);
        check("speed", int'(speed), m_speed);
        check("tick", int'(tick), int'(m_tick));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mode_press();
        mode_flag = 1'b1; mode_value = 1'b0; step(1); mode_flag = 1'b0;
    endtask

    task automatic mode_release();
        mode_flag = 1'b1; mode_value = 1'b1; step(1); mode_flag = 1'b0;
    endtask

    task automatic spd_press();
        spd_flag = 1'b1; spd_value = 1'b0; step(1); spd_flag = 1'b0;
    endtask

    task automatic spd_release();
        spd_flag = 1'b1; spd_value = 1'b1; step(1); spd_flag = 1'b0;
    endtask

    initial begin
        step(3);
        check("rst_led", int'(led), 1);
        check("rst_tick", int'(tick), 0);
        rst_n = 1'b1;

        // run right from reset
        step(8);
        check("rr_led1", int'(led), 8);
        check("rr_tick1", int'(tick), 1);
        step(1);
        check("rr_tick_lo", int'(tick), 0);
        step(7);
        check("rr_led2", int'(led), 4);
        step(16);
        check("rr_led4", int'(led), 1);

        // mode cycle
        mode_press();
        check("m1_mode", int'(mode), 1);
        check("m1_tick", int'(tick), 0);
        step(1); mode_release();
        step(6);
        check("rl_led", int'(led), 2);
        check("rl_tick", int'(tick), 1);
        mode_press();
        check("m2_led", int'(led), 15);
        step(1); mode_release();
        step(6);
        check("bl_led1", int'(led), 0);
        step(8);
        check("bl_led2", int'(led), 15);
        mode_press();
        check("m3_mode", int'(mode), 3);
        check("m3_led", int'(led), 0);
        step(1); mode_release();
        step(6);
        check("off_tick", int'(tick), 1);
        check("off_led", int'(led), 0);
        mode_press();
        check("m0_mode", int'(mode), 0);
        step(1); mode_release();

        // duplicate flag without release
        mode_press();
        step(2);
        mode_press();
        check("dup_mode", int'(mode), 1);
        step(1); mode_release();

        // back to RUN_R, park divider at 6
        repeat (3) begin
            mode_press(); step(1); mode_release();
        end
        check("rr_again", int'(mode), 0);
        step(4);

        // speed press mid-count
        spd_press();
`ifdef LED_SPEED_EN
        check("spd1", int'(speed), 1);
        check("spd1_led", int'(led), 1);
        step(1); spd_release();
        step(2);
        check("spd1_step", int'(led), 8);
        check("spd1_tick", int'(tick), 1);
        repeat (2) begin
            spd_press(); step(1); spd_release();
        end
        check("spd_wrap", int'(speed), 0);
`else
        check("nospd", int'(speed), 0);
        step(1);
        check("nospd_step", int'(led), 8);
        spd_release();
        repeat (2) begin
            spd_press(); step(1); spd_release();
        end
        check("nospd2", int'(speed), 0);
`endif

        // simultaneous mode and speed press
        mode_flag = 1'b1; mode_value = 1'b0; spd_flag = 1'b1; spd_value = 1'b0;
        step(1);
        mode_flag = 1'b0; spd_flag = 1'b0;
        check("col_mode", int'(mode), 1);
        check("col_led", int'(led), 1);
`ifdef LED_SPEED_EN
        check("col_speed", int'(speed), 1);
`else
        check("col_speed", int'(speed), 0);
`endif
        step(1);
        mode_flag = 1'b1; mode_value = 1'b1; spd_flag = 1'b1; spd_value = 1'b1;
        step(1);
        mode_flag = 1'b0; spd_flag = 1'b0;
        // divider now 2; advance to terminal count
`ifdef LED_SPEED_EN
        step(TM - 3);
`else
        step(TS - 3);
`endif
        mode_press();
        check("wrap_tick", int'(tick), 0);
        check("wrap_led", int'(led), 15);
        step(1); mode_release();
        step(1);

        // async reset during BLINK at cnt 3
        #2 rst_n = 1'b0;
        #1;
        check("ar_led", int'(led), 1);
        check("ar_mode", int'(mode), 0);
        check("ar_speed", int'(speed), 0);
        step(2);
        rst_n = 1'b1;
        step(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
